// File: rtl/iom_wb_bridge.sv
// MicroBlaze MCS IO bus to multi-channel Wishbone classic bridge.
// One registered Wishbone cycle per IO access, with per-access timeout and error counting.
module iom_wb_bridge #(
    parameter int          NCH      = 4,
    parameter int          CH_AW    = 5,
    parameter int          DW       = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_addr_strobe,
    input  logic                io_read_strobe,
    input  logic                io_write_strobe,
    input  logic [11:0]         io_address,
    input  logic [3:0]          io_byte_enable,
    input  logic [31:0]         io_write_data,
    output logic [31:0]         io_read_data,
    output logic                io_ready,
    output logic [CH_AW-3:0]    wb_adr_o,
    output logic [DW-1:0]       wb_dat_o,
    output logic [DW/8-1:0]     wb_sel_o,
    output logic                wb_we_o,
    output logic [NCH-1:0]      wb_cyc_o,
    output logic [NCH-1:0]      wb_stb_o,
    input  logic [NCH*DW-1:0]   wb_dat_i,
    input  logic [NCH-1:0]      wb_ack_i,
    output logic                bus_err,
    output logic [7:0]          err_count
);

    localparam int CHB = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = DW / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t          state_r;
    logic [CHB-1:0]  ch_r;
    logic [15:0]     tmo_r;
    logic [11:0]     upper_s;
    logic            mapped_s;
    logic [CHB-1:0]  ch_s;
    logic [NCH-1:0]  cyc_s;
    logic            ack_s;
    logic [DW-1:0]   rdat_s;
    logic [SW-1:0]   sel_s;

    // Channel decode of the incoming address and selection of the active slave's response.
    always_comb begin
        upper_s  = io_address >> CH_AW;
        mapped_s = (upper_s < 12'(NCH));
        ch_s     = upper_s[CHB-1:0];
        for (int i = 0; i < NCH; i++) begin
            cyc_s[i] = (ch_s == CHB'(i));
        end
        ack_s  = wb_ack_i[ch_r];
        rdat_s = wb_dat_i[ch_r*DW +: DW];
        if (io_write_strobe) begin
            sel_s = io_byte_enable[SW-1:0];
        end else begin
            sel_s = {SW{1'b1}};
        end
    end

    assign wb_stb_o = wb_cyc_o;

    // Access sequencer: accept in IDLE, wait for ack or timeout in BUSY, one-cycle RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ch_r         <= '0;
            tmo_r        <= 16'd0;
            io_read_data <= 32'd0;
            io_ready     <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= '0;
            bus_err      <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            io_ready     <= 1'b0;
            io_read_data <= 32'd0;
            bus_err      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (io_addr_strobe) begin
                        if (mapped_s) begin
                            ch_r     <= ch_s;
                            wb_adr_o <= io_address[CH_AW-1:2];
                            wb_dat_o <= io_write_data[DW-1:0];
                            wb_we_o  <= io_write_strobe;
                            wb_sel_o <= sel_s;
                            wb_cyc_o <= cyc_s;
                            tmo_r    <= 16'd0;
                            state_r  <= BUSY;
                        end else begin
                            io_ready <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the terminal-count cycle still completes normally.
                    if (ack_s) begin
                        wb_cyc_o     <= '0;
                        io_ready     <= 1'b1;
                        io_read_data <= 32'(rdat_s);
                        state_r      <= RESP;
                    end else if (tmo_r == 16'(TIMEOUT)) begin
                        wb_cyc_o     <= '0;
                        io_ready     <= 1'b1;
                        io_read_data <= ERR_DATA;
                        bus_err      <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state_r      <= RESP;
                    end else begin
                        tmo_r <= tmo_r + 16'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    wb_cyc_o <= '0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iom_wb_bridge.sv
// Self-checking bench for iom_wb_bridge: directed plan items plus randomized accesses
// checked against a transaction-level model of the bridge.
module tb_iom_wb_bridge;

    localparam int          NCH   = 4;
    localparam int          CH_AW = 5;
    localparam int          DW    = 8;
    localparam int          TO    = 255;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [11:0]       io_address;
    logic [3:0]        io_byte_enable;
    logic [31:0]       io_write_data;
    logic [31:0]       io_read_data;
    logic              io_ready;
    logic [CH_AW-3:0]  wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic              wb_we_o;
    logic [NCH-1:0]    wb_cyc_o, wb_stb_o;
    logic [NCH*DW-1:0] wb_dat_i;
    logic [NCH-1:0]    wb_ack_i;
    logic              bus_err;
    logic [7:0]        err_count;

    logic              sat_stb;
    logic [31:0]       sat_rdata;
    logic              sat_ready;
    logic [CH_AW-3:0]  sat_adr;
    logic [DW-1:0]     sat_dat;
    logic [DW/8-1:0]   sat_sel;
    logic              sat_we;
    logic [NCH-1:0]    sat_cyc, sat_stbo;
    logic [NCH-1:0]    sat_ack;
    logic              sat_err;
    logic [7:0]        sat_count;

    int nvec = 0;
    int nerr = 0;
    int ec_m = 0;
    int sat_m = 0;

    always #5 clk = ~clk;

    iom_wb_bridge #(.NCH(NCH), .CH_AW(CH_AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .bus_err(bus_err), .err_count(err_count)
    );

    // Short-timeout instance used only to reach error-counter saturation quickly.
    iom_wb_bridge #(.NCH(NCH), .CH_AW(CH_AW), .DW(DW), .TIMEOUT(2), .ERR_DATA(ERRD)) u_sat (
        .clk(clk), .rst(rst),
        .io_addr_strobe(sat_stb), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(sat_rdata), .io_ready(sat_ready),
        .wb_adr_o(sat_adr), .wb_dat_o(sat_dat), .wb_sel_o(sat_sel), .wb_we_o(sat_we),
        .wb_cyc_o(sat_cyc), .wb_stb_o(sat_stbo), .wb_dat_i(wb_dat_i), .wb_ack_i(sat_ack),
        .bus_err(sat_err), .err_count(sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One IO access. d = cycle (0 = first cyc cycle) at which the slave acks, -1 = never.
    task automatic access(input logic [11:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] be, input int d, input int fd);
        int             ch;
        bit             mapped;
        bit             tmo;
        bit             bad_cyc;
        int             k;
        int             exp_len;
        logic [7:0]     sdat [NCH];
        logic [NCH-1:0] one;
        logic [NCH-1:0] oh;
        logic [31:0]    exp_rd;
        ch     = int'(addr >> CH_AW);
        mapped = (ch < NCH);
        one    = 1;
        oh     = one << ch;
        for (int i = 0; i < NCH; i++) begin
            sdat[i] = 8'($urandom);
            if (i == ch && fd >= 0) sdat[i] = 8'(fd);
            wb_dat_i[i*DW +: DW] = sdat[i];
        end
        @(negedge clk);
        chk("idle_ready", {31'd0, io_ready}, 32'd0);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = !wr;
        io_write_strobe = wr;
        io_address      = addr;
        io_byte_enable  = be;
        io_write_data   = wdata;
        @(negedge clk);
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        if (!mapped) begin
            chk("unmap_ready", {31'd0, io_ready}, 32'd1);
            chk("unmap_data", io_read_data, 32'd0);
            chk("unmap_cyc", {28'd0, wb_cyc_o}, 32'd0);
            @(negedge clk);
            chk("unmap_ready_drop", {31'd0, io_ready}, 32'd0);
            return;
        end
        chk("cyc", {28'd0, wb_cyc_o}, {28'd0, oh});
        chk("stb", {28'd0, wb_stb_o}, {28'd0, oh});
        chk("adr", {29'd0, wb_adr_o}, {29'd0, addr[4:2]});
        chk("dat", {24'd0, wb_dat_o}, {24'd0, wdata[7:0]});
        chk("we", {31'd0, wb_we_o}, {31'd0, wr});
        chk("sel", {31'd0, wb_sel_o}, wr ? {31'd0, be[0]} : 32'd1);
        k = 0;
        bad_cyc = 1'b0;
        while (wb_cyc_o !== '0 && k < 2000) begin
            if (wb_cyc_o !== oh || io_ready !== 1'b0) bad_cyc = 1'b1;
            wb_ack_i       = (NCH'($urandom) & ~oh) | ((k == d) ? oh : '0);
            io_addr_strobe = ($urandom_range(0, 5) == 0);
            io_read_strobe = 1'b1;
            io_address     = 12'($urandom);
            @(negedge clk);
            k++;
        end
        wb_ack_i       = '0;
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        tmo     = !(d >= 0 && d <= TO);
        exp_len = tmo ? TO + 1 : d + 1;
        exp_rd  = tmo ? ERRD : {24'd0, sdat[ch]};
        if (tmo) ec_m = (ec_m < 255) ? ec_m + 1 : 255;
        chk("cyc_len", k, exp_len);
        chk("cyc_stable", {31'd0, bad_cyc}, 32'd0);
        chk("ready", {31'd0, io_ready}, 32'd1);
        chk("rdata", io_read_data, exp_rd);
        chk("bus_err", {31'd0, bus_err}, {31'd0, tmo});
        chk("err_count", {24'd0, err_count}, 32'(ec_m));
        chk("adr_hold", {29'd0, wb_adr_o}, {29'd0, addr[4:2]});
        @(negedge clk);
        chk("resp_ready", {31'd0, io_ready}, 32'd0);
        chk("resp_data", io_read_data, 32'd0);
        chk("resp_err", {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_address = 12'd0; io_byte_enable = 4'd0; io_write_data = 32'd0;
        wb_dat_i = '0; wb_ack_i = '0; sat_stb = 1'b0; sat_ack = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, io_ready}, 32'd0);
        chk("rst_data", io_read_data, 32'd0);
        chk("rst_cyc", {28'd0, wb_cyc_o}, 32'd0);
        chk("rst_adr", {29'd0, wb_adr_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;

        access(12'h04C, 1'b1, 32'h0000005A, 4'h1, 2, -1);
        access(12'h020, 1'b0, 32'h0, 4'h0, 0, 8'hA5);
        access(12'h400, 1'b0, 32'h0, 4'h0, 0, -1);
        access(12'h060, 1'b0, 32'h0, 4'h0, -1, -1);
        access(12'h070, 1'b0, 32'h0, 4'h0, TO, -1);
        access(12'h004, 1'b1, 32'h12345678, 4'hE, TO, -1);

        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            int          dd;
            a  = {4'd0, 3'($urandom_range(0, 5)), 5'($urandom)};
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            dd = $urandom_range(0, 6);
            if (i % 13 == 7) dd = -1;
            access(a, 1'($urandom), $urandom, 4'($urandom), dd, -1);
        end

        // Reset while busy on channel 0.
        @(negedge clk);
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = 12'h008;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_cyc", {28'd0, wb_cyc_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ec_m = 0;
        chk("midrst_cyc", {28'd0, wb_cyc_o}, 32'd0);
        chk("midrst_ready", {31'd0, io_ready}, 32'd0);
        chk("midrst_errcnt", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        chk("midrst_noready", {31'd0, io_ready}, 32'd0);
        access(12'h00C, 1'b0, 32'h0, 4'h0, 1, -1);

        // Error counter saturation on the short-timeout instance.
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            sat_stb = 1'b1; io_read_strobe = 1'b1; io_address = 12'h000;
            @(negedge clk);
            sat_stb = 1'b0; io_read_strobe = 1'b0;
            n = 0;
            while (sat_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            sat_m = (sat_m < 255) ? sat_m + 1 : 255;
            chk("sat_ready", {31'd0, sat_ready}, 32'd1);
            chk("sat_data", sat_rdata, ERRD);
            chk("sat_err", {31'd0, sat_err}, 32'd1);
            chk("sat_count", {24'd0, sat_count}, 32'(sat_m));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iom_wb_bridge.md
Name: iom_wb_bridge

Overview:
Parametrised MicroBlaze IO bus to multi-slave Wishbone bridge, the successor to the single-core I2C IO wrapper. It decodes the IO address into NCH equal channel windows and runs one registered Wishbone classic cycle per IO access. It adds byte-select pass-through, per-access timeout with error response, and an error counter. It sits between the MCS IO bus and a bank of Wishbone peripherals (I2C, SPI, UART cores).

Parameters:
NCH, 4, number of Wishbone slave channels (1..8)
CH_AW, 5, byte-address bits per channel window; slave word address = CH_AW-2 bits
DW, 8, Wishbone data width (8, 16 or 32)
TIMEOUT, 255, max cycles waiting for ack before error (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
io_addr_strobe  in  1  IO access start
io_read_strobe  in  1  read access
io_write_strobe  in  1  write access
io_address  in  12  byte address
io_byte_enable  in  4  byte lanes
io_write_data  in  32  write data
io_read_data  out  32  read data, valid with io_ready
io_ready  out  1  single-cycle access completion
wb_adr_o  out  CH_AW-2  word address within channel (shared)
wb_dat_o  out  DW  write data (shared)
wb_sel_o  out  DW/8  byte select (shared)
wb_we_o  out  1  write enable (shared)
wb_cyc_o  out  NCH  per-channel cycle
wb_stb_o  out  NCH  per-channel strobe (equals wb_cyc_o)
wb_dat_i  in  NCH*DW  concatenated slave read data, channel 0 in LSBs
wb_ack_i  in  NCH  per-channel ack
bus_err  out  1  one-cycle pulse on timeout
err_count  out  8  saturating timeout count

Behaviour:
- Reset: all outputs 0; FSM IDLE; timeout counter 0; err_count 0. Reset mid-cycle drops cyc/stb at the next edge, no io_ready issued.
- Decode: ch = io_address[CH_AW+clog2(NCH)-1 : CH_AW]; mapped iff all io_address bits above that field are 0 and ch < NCH.
- FSM states IDLE, BUSY, RESP.
- IDLE, strobe at cycle t, mapped: latch adr = io_address[CH_AW-1:2], dat = io_write_data[DW-1:0], we = io_write_strobe, sel = io_byte_enable[DW/8-1:0] on writes, all ones on reads. Assert wb_cyc_o[ch]/wb_stb_o[ch] from t+1 -> BUSY.
- IDLE, strobe, unmapped: io_ready=1 at t+1 with io_read_data=0, no Wishbone activity, stay IDLE.
- BUSY: timeout counter clears on entry and increments each cycle.
  - wb_ack_i[ch] high at cycle k: at edge k+1 drop cyc/stb, io_ready=1 for one cycle, io_read_data = zero-extended slave DW data captured at k -> RESP. Fixed latency: ack to io_ready = 1 cycle.
  - Counter reaching TIMEOUT with no ack: drop cyc/stb, io_ready=1 next cycle with io_read_data=ERR_DATA (writes: ERR_DATA also driven, ignored), bus_err pulse, err_count +1 saturating at 255.
  - Ack in the same cycle as the timeout terminal count: ack wins, no error.
  - Acks from non-selected channels are ignored.
- RESP: one cycle, io_ready and io_read_data drop to 0 -> IDLE. Minimum access = 3 cycles strobe-to-next-accept.
- io_addr_strobe outside IDLE: ignored, with no state change (protocol violation).
- io_read_data and io_ready are 0 whenever io_ready is not asserted.
- Shared wb_adr_o/dat_o/sel_o/we_o hold their latched values until the next accepted access.

Test Plan:
- Write 0x5A to ch2 reg 3 (addr 0x04C); slave acks 2 cycles after cyc -> cyc_o=4'b0100, adr=3, dat=0x5A, we=1, sel=1; io_ready 1 cycle after ack.
- Read ch1 reg 0 (addr 0x020); slave returns 0xA5 with same-cycle ack -> io_read_data=0x000000A5 one cycle after ack; cyc high exactly 1 cycle.
- Access addr 0x400 (unmapped) -> io_ready next cycle, data 0, all wb_cyc_o=0.
- Read ch3 with no ack, TIMEOUT=255 -> io_ready after 256 cycles, data 0xDEADBEEF, bus_err pulse, err_count=1; 256 further timeouts leave err_count=255.
- Ack asserted exactly at the terminal count -> normal data returned, bus_err stays 0.
- Assert rst while BUSY on ch0 -> wb_cyc_o=0 next edge, no io_ready; next access completes normally.
